// File: rtl/double_serializador_n.sv
// Half-word serializer: captures an N-bit word on start and offers its two halves on a valid/ready port.
// Optional even-parity output on the offered half when DOUBLE_SERIALIZADOR_PARITY_EN is defined.
module double_serializador_n #(
    parameter int N         = 8,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           start,
    input  logic [N-1:0]   D,
    input  logic           half_ready,
    output logic [N/2-1:0] D_half,
    output logic           half_valid,
    output logic           is_high,
    output logic           busy,
`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
    output logic           done,
    output logic           half_parity
`else
    output logic           done
`endif
);

    localparam int H = N / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [N-1:0] word;
    logic [H-1:0] low_half;
    logic [H-1:0] high_half;
    logic         transfer;

    assign low_half  = word[H-1:0];
    assign high_half = word[N-1:H];
    assign transfer  = half_valid && half_ready;

    // The word register only loads on an accepted start, so D is ignored while busy.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            word  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                word <= D;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = FIRST;
            FIRST:   if (transfer) next_state = SECOND;
            SECOND:  if (transfer) next_state = DONE;
            DONE:                  next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Outputs depend only on registered state and the captured word.
    always_comb begin
        D_half     = '0;
        half_valid = 1'b0;
        is_high    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            FIRST: begin
                half_valid = 1'b1;
                busy       = 1'b1;
                is_high    = !LOW_FIRST;
                D_half     = LOW_FIRST ? low_half : high_half;
            end
            SECOND: begin
                half_valid = 1'b1;
                busy       = 1'b1;
                is_high    = LOW_FIRST;
                D_half     = LOW_FIRST ? high_half : low_half;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                D_half = '0;
            end
        endcase
    end

`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
    // D_half is forced to zero whenever no half is offered, so parity is zero there too.
    assign half_parity = ^D_half;
`endif

endmodule

// File: tb/tb_double_serializador_n.sv
// Scoreboard bench for double_serializador_n: an 8-bit low-first instance and a 16-bit high-first instance.
module tb_double_serializador_n;

    typedef struct {
        bit          is_done;
        bit          hi;
        logic [15:0] data;
    } exp_t;

    logic clock;
    int   checks;
    int   errors;

    exp_t exp_a[$];
    exp_t exp_b[$];

    logic        clear_a, start_a, ready_a;
    logic [7:0]  d_a;
    logic [3:0]  half_a;
    logic        valid_a, hi_a, busy_a, done_a;

    logic        clear_b, start_b, ready_b;
    logic [15:0] d_b;
    logic [7:0]  half_b;
    logic        valid_b, hi_b, busy_b, done_b;

`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
    logic parity_a, parity_b;
`endif

    double_serializador_n #(.N(8), .LOW_FIRST(1'b1)) dut_a (
        .clock(clock), .clear(clear_a), .start(start_a), .D(d_a), .half_ready(ready_a),
        .D_half(half_a), .half_valid(valid_a), .is_high(hi_a), .busy(busy_a),
`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
        .done(done_a), .half_parity(parity_a)
`else
        .done(done_a)
`endif
    );

    double_serializador_n #(.N(16), .LOW_FIRST(1'b0)) dut_b (
        .clock(clock), .clear(clear_b), .start(start_b), .D(d_b), .half_ready(ready_b),
        .D_half(half_b), .half_valid(valid_b), .is_high(hi_b), .busy(busy_b),
`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
        .done(done_b), .half_parity(parity_b)
`else
        .done(done_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mkHalf(input bit hi, input logic [15:0] data);
        exp_t e;
        e.is_done = 1'b0;
        e.hi      = hi;
        e.data    = data;
        return e;
    endfunction

    function automatic exp_t mkDone();
        exp_t e;
        e.is_done = 1'b1;
        e.hi      = 1'b0;
        e.data    = '0;
        return e;
    endfunction

    // Monitor for instance A: peeks the expected half while stalled, pops on transfer or done.
    always @(negedge clock) begin
        exp_t e;
        if (valid_a) begin
            if (exp_a.size() == 0) begin
                if (ready_a) checkOutput("a_unexpected_half", {28'd0, half_a}, 32'hFFFF_FFFF);
            end else begin
                e = exp_a[0];
                checkOutput("a_half_kind", {31'd0, e.is_done}, 32'd0);
                checkOutput("a_D_half", {28'd0, half_a}, {28'd0, e.data[3:0]});
                checkOutput("a_is_high", {31'd0, hi_a}, {31'd0, e.hi});
`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
                checkOutput("a_parity", {31'd0, parity_a}, {31'd0, ^e.data[3:0]});
`endif
                if (ready_a) void'(exp_a.pop_front());
            end
        end else begin
            checkOutput("a_idle_half_zero", {27'd0, hi_a, half_a}, 32'd0);
`ifdef DOUBLE_SERIALIZADOR_PARITY_EN
            checkOutput("a_idle_parity", {31'd0, parity_a}, 32'd0);
`endif
        end
        if (done_a) begin
            if (exp_a.size() == 0) begin
                checkOutput("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_a.pop_front();
                checkOutput("a_done_kind", {31'd0, e.is_done}, 32'd1);
            end
        end
    end

    // Monitor for instance B, same scheme with an 8-bit half.
    always @(negedge clock) begin
        exp_t e;
        if (valid_b) begin
            if (exp_b.size() == 0) begin
                if (ready_b) checkOutput("b_unexpected_half", {24'd0, half_b}, 32'hFFFF_FFFF);
            end else begin
                e = exp_b[0];
                checkOutput("b_half_kind", {31'd0, e.is_done}, 32'd0);
                checkOutput("b_D_half", {24'd0, half_b}, {24'd0, e.data[7:0]});
                checkOutput("b_is_high", {31'd0, hi_b}, {31'd0, e.hi});
                if (ready_b) void'(exp_b.pop_front());
            end
        end else begin
            checkOutput("b_idle_half_zero", {23'd0, hi_b, half_b}, 32'd0);
        end
        if (done_b) begin
            if (exp_b.size() == 0) begin
                checkOutput("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_b.pop_front();
                checkOutput("b_done_kind", {31'd0, e.is_done}, 32'd1);
            end
        end
    end

    // Pulses start on instance A for one cycle; leaves the caller one cycle after the accepting edge.
    task automatic applyStimulus(input logic [7:0] d, input logic ready);
        start_a = 1'b1;
        d_a     = d;
        ready_a = ready;
        @(posedge clock);
        #1;
        start_a = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clear_a = 1'b1; start_a = 1'b0; ready_a = 1'b0; d_a = 8'h00;
        clear_b = 1'b1; start_b = 1'b0; ready_b = 1'b0; d_b = 16'h0000;
        @(posedge clock);
        #1;
        clear_a = 1'b0;
        clear_b = 1'b0;
        checkOutput("reset_busy_a", {31'd0, busy_a}, 32'd0);
        checkOutput("reset_outputs_a", {25'd0, half_a, valid_a, hi_a, done_a}, 32'd0);
        checkOutput("reset_busy_b", {31'd0, busy_b}, 32'd0);
        waitCycles(1);

        // Plain low-first transfer.
        exp_a.push_back(mkHalf(1'b0, 16'h5));
        exp_a.push_back(mkHalf(1'b1, 16'hA));
        exp_a.push_back(mkDone());
        applyStimulus(8'hA5, 1'b1);
        checkOutput("busy_in_first", {31'd0, busy_a}, 32'd1);
        waitCycles(3);
        checkOutput("busy_after_done", {31'd0, busy_a}, 32'd0);

        // Consumer stalls for three cycles while the first half is held.
        exp_a.push_back(mkHalf(1'b0, 16'hC));
        exp_a.push_back(mkHalf(1'b1, 16'h3));
        exp_a.push_back(mkDone());
        applyStimulus(8'h3C, 1'b0);
        waitCycles(3);
        ready_a = 1'b1;
        waitCycles(4);
        checkOutput("busy_after_stall", {31'd0, busy_a}, 32'd0);

        // Start held high through the whole sequence must not reload or restart.
        exp_a.push_back(mkHalf(1'b0, 16'h2));
        exp_a.push_back(mkHalf(1'b1, 16'h1));
        exp_a.push_back(mkDone());
        applyStimulus(8'h12, 1'b0);
        start_a = 1'b1;
        d_a     = 8'hFF;
        waitCycles(1);
        ready_a = 1'b1;
        waitCycles(3);
        start_a = 1'b0;
        checkOutput("busy_after_ignored_start", {31'd0, busy_a}, 32'd0);
        waitCycles(2);

        // Clear during SECOND abandons the second half and the done pulse.
        exp_a.push_back(mkHalf(1'b0, 16'h7));
        applyStimulus(8'h77, 1'b1);
        waitCycles(1);
        ready_a = 1'b0;
        clear_a = 1'b1;
        waitCycles(1);
        clear_a = 1'b0;
        checkOutput("clear_outputs", {25'd0, half_a, valid_a, hi_a, done_a}, 32'd0);
        checkOutput("clear_busy", {31'd0, busy_a}, 32'd0);
        waitCycles(2);
        exp_a.push_back(mkHalf(1'b0, 16'h1));
        exp_a.push_back(mkHalf(1'b1, 16'h8));
        exp_a.push_back(mkDone());
        applyStimulus(8'h81, 1'b1);
        waitCycles(4);

        // Clear and start together: nothing is captured.
        clear_a = 1'b1;
        applyStimulus(8'h5A, 1'b1);
        clear_a = 1'b0;
        checkOutput("clear_start_busy", {31'd0, busy_a}, 32'd0);
        waitCycles(2);

        // Parity vector (parity checked by the monitor when enabled).
        exp_a.push_back(mkHalf(1'b0, 16'h1));
        exp_a.push_back(mkHalf(1'b1, 16'h7));
        exp_a.push_back(mkDone());
        applyStimulus(8'h71, 1'b1);
        waitCycles(4);

        // High-first 16-bit instance.
        exp_b.push_back(mkHalf(1'b1, 16'hBE));
        exp_b.push_back(mkHalf(1'b0, 16'hEF));
        exp_b.push_back(mkDone());
        start_b = 1'b1;
        d_b     = 16'hBEEF;
        ready_b = 1'b1;
        waitCycles(1);
        start_b = 1'b0;
        d_b     = 16'h1234;
        checkOutput("busy_b_first", {31'd0, busy_b}, 32'd1);
        waitCycles(4);
        checkOutput("busy_b_after", {31'd0, busy_b}, 32'd0);

        checkOutput("queue_a_drained", exp_a.size(), 32'd0);
        checkOutput("queue_b_drained", exp_b.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/double_serializador_n.md
Name: double_serializador_n

Overview:
Splits an N-bit word into two N/2-bit halves and presents them one at a time on a valid/ready half-width port. It is the sending end of the half-word load interface, where the receiver loads the low half, then the high half, into an N-bit register. It sits between a full-width source (e.g. a data register) and a narrow consumer or link. The block captures the word on start, emits both halves in a fixed order, then pulses done.

Parameters:
N, 8, full word width; must be even and >= 2
LOW_FIRST, 1, 1 = send low half first then high half; 0 = high half first then low half

Ports:
clock  input  1  system clock; all state updates on rising edge
clear  input  1  synchronous active-high reset, sampled on rising edge of clock
start  input  1  request to send D; accepted only in IDLE
D  input  N  word to send; captured in the cycle start is accepted
half_ready  input  1  consumer accepts D_half this cycle
D_half  output  N/2  current half being offered
half_valid  output  1  D_half holds a valid half
is_high  output  1  1 = D_half is the high half D[N-1:N/2]; 0 = low half D[N/2-1:0]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the second half is transferred

Behaviour:
- Reset: clear has priority over all inputs and is synchronous. After the clearing edge:
  - state = IDLE, captured word = 0
  - D_half = 0, half_valid = 0, is_high = 0, busy = 0, done = 0
- FSM states: IDLE, FIRST, SECOND, DONE. The state is registered.
  - Outputs are decoded from the state register and the captured-word register only. There is no combinational path from any input to any output.
- IDLE:
  - If start = 1, capture D into the word register and go to FIRST.
  - If start = 0, stay in IDLE.
- FIRST:
  - half_valid = 1.
  - D_half = low half and is_high = 0 if LOW_FIRST = 1; otherwise high half and is_high = 1.
  - A transfer occurs on an edge where half_valid = 1 and half_ready = 1; the state then goes to SECOND.
  - If half_ready = 0, stay in FIRST; D_half and is_high hold stable.
- SECOND:
  - half_valid = 1; carries the other half, with is_high set to match.
  - On transfer, go to DONE; otherwise hold.
- DONE:
  - half_valid = 0, done = 1 for exactly one cycle, then go to IDLE unconditionally.
- busy = 1 in FIRST, SECOND and DONE.
- Latency with half_ready held at 1:
  - start sampled at edge t -> first half valid after t
  - second half valid after t+1
  - done after t+2
  - IDLE again after t+3
  - Minimum spacing between accepted starts is 4 cycles.
- In IDLE and DONE, D_half = 0 and is_high = 0.
- start while busy: ignored. The word register is not reloaded and the sequence in progress is unaffected. start in DONE is also ignored.
- Changes on D after capture have no effect until the next accepted start.
- half_ready asserted while half_valid = 0: no effect.
- clear mid-sequence (FIRST or SECOND): returns to IDLE at the clearing edge with no done pulse; the partial transfer is abandoned.
- clear and start in the same cycle: clear wins and the word is not captured.

Optional Feature:
Macro: DOUBLE_SERIALIZADOR_PARITY_EN
- Defined:
  - Adds output half_parity (1 bit) = XOR of all bits of D_half (even parity), valid whenever half_valid = 1.
  - half_parity = 0 when half_valid = 0 and after clear.
  - It is decoded from registered state, like the other outputs.
- Not defined: the half_parity port and its logic do not exist; all other behaviour is identical.

Test Plan:
- N=8, LOW_FIRST=1, half_ready=1, D=0xA5, start for 1 cycle -> D_half=0x5/is_high=0, next cycle D_half=0xA/is_high=1, next cycle done=1 for 1 cycle, then busy=0.
- N=8, D=0x3C, half_ready=0 for 3 cycles after start, then 1 -> D_half stays 0xC with half_valid=1 for 4 cycles, then 0x3 with is_high=1, then done pulse.
- Start D=0x12; during FIRST, assert start with D=0xFF -> halves emitted are 0x2 then 0x1; no second sequence starts.
- Start D=0x77; clear during SECOND -> next cycle all outputs 0, state IDLE, no done pulse; new start with D=0x81 sends 0x1 then 0x8 normally.
- LOW_FIRST=0, N=16, D=0xBEEF, half_ready=1 -> D_half=0xBE/is_high=1, then 0xEF/is_high=0, then done.
- With DOUBLE_SERIALIZADOR_PARITY_EN defined, N=8, D=0x71 -> half_parity=1 for 0x1, then 1 for 0x7; half_parity=0 in IDLE.
